mux4_rr_arbiter: RTL and testbench

- Round-robin arbiter that shares one 4-to-1, 1-bit multiplexer among four requesters.
- Each requester drives one data bit and one request line. The block grants one owner at a time, drives the mux select pair (s1,s0) and forwards the owner's bit on f.
- A hold limit bounds each grant so that one requester cannot starve the others.
- Sits between lab requester logic and the shared mux datapath.

---
 rtl/mux4_rr_arbiter_if.sv | 24 ++
 rtl/mux4_rr_arbiter.sv | 105 ++++++++++
 tb/tb_mux4_rr_arbiter.sv | 155 +++++++++++++++
 3 files changed

// File: rtl/mux4_rr_arbiter_if.sv
// Bus between the four requesters and the shared 4-to-1 mux arbiter.
// The master side drives the requests and data. The slave side is the arbiter.
interface mux4_rr_arbiter_if;
    logic [3:0] req;
    logic       a0;
    logic       a1;
    logic       a2;
    logic       a3;
    logic [3:0] gnt;
    logic       s1;
    logic       s0;
    logic       busy;
    logic       f;

    modport master (
        output req, a0, a1, a2, a3,
        input  gnt, s1, s0, busy, f
    );

    modport slave (
        input  req, a0, a1, a2, a3,
        output gnt, s1, s0, busy, f
    );
endinterface

// File: rtl/mux4_rr_arbiter.sv
// Round-robin arbiter that owns the select pair of a shared 4-to-1 mux and enforces a hold limit.
// Defining MUX4_ARB_FIXED_PRIO_EN selects fixed priority instead (req[0] highest).
//
//   state | meaning
//   IDLE  | no owner, f forced low; arbitrate on the next edge when any req is set
//   GRANT | owner {s1,s0} holds the mux until its req drops or hold_cnt hits MAX_HOLD
module mux4_rr_arbiter #(
    parameter int MAX_HOLD = 8,
    parameter int HCW      = 8
) (
    input  logic            clk,
    input  logic            rst_n,
    mux4_rr_arbiter_if.slave bus
);

    typedef enum logic {IDLE, GRANT} state_t;

    state_t         state;
    logic [HCW-1:0] hold_cnt;
    logic [1:0]     winner;
    logic [1:0]     owner;
    logic [3:0]     a_vec;
    logic           release_now;

    assign owner       = {bus.s1, bus.s0};
    assign a_vec       = {bus.a3, bus.a2, bus.a1, bus.a0};
    assign release_now = !bus.req[owner] || (hold_cnt == HCW'(MAX_HOLD));
    assign bus.f       = bus.busy & a_vec[owner];

`ifdef MUX4_ARB_FIXED_PRIO_EN
    always_comb begin
        winner = 2'd0;
        for (int k = 3; k >= 0; k--) begin
            if (bus.req[k]) winner = 2'(k);
        end
    end
`else
    logic [1:0] last;

    // Search starts just after the previous winner, so it ends up with the lowest priority.
    always_comb begin
        logic [1:0] idx;
        logic       found;
        winner = 2'd0;
        found  = 1'b0;
        idx    = 2'd0;
        for (int k = 1; k <= 4; k++) begin
            idx = last + 2'(k);
            if (!found && bus.req[idx]) begin
                winner = idx;
                found  = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last <= 2'd3;
        end else if (state == IDLE && |bus.req) begin
            last <= winner;
        end
    end
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            bus.gnt  <= 4'b0000;
            bus.s1   <= 1'b0;
            bus.s0   <= 1'b0;
            bus.busy <= 1'b0;
            hold_cnt <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (|bus.req) begin
                        state            <= GRANT;
                        bus.gnt          <= 4'b0001 << winner;
                        {bus.s1, bus.s0} <= winner;
                        bus.busy         <= 1'b1;
                        hold_cnt         <= HCW'(1);
                    end
                end
                GRANT: begin
                    // Select pair is left alone on release; f is gated by busy anyway.
                    if (release_now) begin
                        state    <= IDLE;
                        bus.gnt  <= 4'b0000;
                        bus.busy <= 1'b0;
                        hold_cnt <= '0;
                    end else begin
                        hold_cnt <= hold_cnt + HCW'(1);
                    end
                end
                default: begin
                    state    <= IDLE;
                    bus.gnt  <= 4'b0000;
                    bus.busy <= 1'b0;
                    hold_cnt <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mux4_rr_arbiter.sv
// Directed bench for mux4_rr_arbiter: dut_a uses MAX_HOLD=8 and dut_b uses MAX_HOLD=2.
// The expected values are computed by hand from the arbitration rules.
module tb_mux4_rr_arbiter;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_tests = 0;
    int   n_fail = 0;

    always #5 clk = ~clk;

    mux4_rr_arbiter_if ia();
    mux4_rr_arbiter_if ib();

    mux4_rr_arbiter #(.MAX_HOLD(8), .HCW(8)) dut_a (.clk(clk), .rst_n(rst_n), .bus(ia));
    mux4_rr_arbiter #(.MAX_HOLD(2), .HCW(8)) dut_b (.clk(clk), .rst_n(rst_n), .bus(ib));

    task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step(input int n = 1);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    logic [3:0] rot_exp [14];
    logic [3:0] fair_first;

    initial begin
        ia.req = 4'b0000; ia.a0 = 1'b0; ia.a1 = 1'b0; ia.a2 = 1'b0; ia.a3 = 1'b0;
        ib.req = 4'b0000; ib.a0 = 1'b0; ib.a1 = 1'b0; ib.a2 = 1'b0; ib.a3 = 1'b0;
`ifdef MUX4_ARB_FIXED_PRIO_EN
        rot_exp = '{4'h1, 4'h1, 4'h0, 4'h1, 4'h1, 4'h0, 4'h1, 4'h1, 4'h0,
                    4'h1, 4'h1, 4'h0, 4'h1, 4'h1};
        fair_first = 4'b0001;
`else
        rot_exp = '{4'h1, 4'h1, 4'h0, 4'h2, 4'h2, 4'h0, 4'h4, 4'h4, 4'h0,
                    4'h8, 4'h8, 4'h0, 4'h1, 4'h1};
        fair_first = 4'b1000;
`endif

        // Values while reset is held
        #12;
        chk("rst_gnt", {4'h0, ia.gnt}, 8'h00);
        chk("rst_busy", {7'h0, ia.busy}, 8'h00);
        chk("rst_sel", {6'h0, ia.s1, ia.s0}, 8'h00);
        chk("rst_f", {7'h0, ia.f}, 8'h00);
        rst_n = 1'b1;

        // Reset asserted in the middle of a grant
        ia.req = 4'b0010; ia.a1 = 1'b1;
        step();
        chk("g1_gnt", {4'h0, ia.gnt}, 8'h02);
        chk("g1_f", {7'h0, ia.f}, 8'h01);
        step();
        #2 rst_n = 1'b0;
        #1;
        chk("async_gnt", {4'h0, ia.gnt}, 8'h00);
        chk("async_busy", {7'h0, ia.busy}, 8'h00);
        chk("async_f", {7'h0, ia.f}, 8'h00);
        #1 rst_n = 1'b1;
        step();
        chk("post_rst_gnt", {4'h0, ia.gnt}, 8'h02);
        chk("post_rst_sel", {6'h0, ia.s1, ia.s0}, 8'h01);
        ia.req = 4'b0000;
        step();
        chk("drop1_gnt", {4'h0, ia.gnt}, 8'h00);
        chk("drop1_sel_kept", {6'h0, ia.s1, ia.s0}, 8'h01);
        step();

        // Single requester 2 with its data bit toggling
        ia.req = 4'b0100; ia.a2 = 1'b0;
        step();
        chk("r2_gnt", {4'h0, ia.gnt}, 8'h04);
        chk("r2_sel", {6'h0, ia.s1, ia.s0}, 8'h02);
        chk("r2_f0", {7'h0, ia.f}, 8'h00);
        ia.a2 = 1'b1; #1;
        chk("r2_f1", {7'h0, ia.f}, 8'h01);
        ia.a2 = 1'b0; #1;
        chk("r2_f0b", {7'h0, ia.f}, 8'h00);
        ia.a2 = 1'b1;
        ia.req = 4'b0000;
        step();
        chk("r2_drop_gnt", {4'h0, ia.gnt}, 8'h00);
        chk("r2_drop_f", {7'h0, ia.f}, 8'h00);
        step();

        // Hold limit: requester 0 stays on the bus for exactly 8 cycles
        ia.req = 4'b0001; ia.a0 = 1'b1;
        step();
        chk("hold_gnt", {4'h0, ia.gnt}, 8'h01);
        for (int i = 1; i < 8; i++) begin
            step();
            chk("hold_busy", {7'h0, ia.busy}, 8'h01);
        end
        step();
        chk("hold_gap_busy", {7'h0, ia.busy}, 8'h00);
        chk("hold_gap_f", {7'h0, ia.f}, 8'h00);
        step();
        chk("hold_regrant", {4'h0, ia.gnt}, 8'h01);

        // Fairness after a forced release, with requesters 0 and 3 both active
        ia.req = 4'b1001;
        step(7);
        chk("fair_still0", {4'h0, ia.gnt}, 8'h01);
        step();
        chk("fair_gap", {4'h0, ia.gnt}, 8'h00);
        step();
        chk("fair_next", {4'h0, ia.gnt}, {4'h0, fair_first});
        step(7);
        step();
        chk("fair_gap2", {7'h0, ia.busy}, 8'h00);
        step();
        chk("fair_back0", {4'h0, ia.gnt}, 8'h01);

        // req[owner] drops on the same edge that the hold limit is reached
        step(7);
        ia.req = 4'b1000;
        step();
        chk("sim_gnt", {4'h0, ia.gnt}, 8'h00);
        chk("sim_busy", {7'h0, ia.busy}, 8'h00);
        chk("sim_f", {7'h0, ia.f}, 8'h00);
        step();
        chk("sim_next", {4'h0, ia.gnt}, 8'h08);
        chk("sim_next_sel", {6'h0, ia.s1, ia.s0}, 8'h03);
        ia.req = 4'b0000;
        step();
        chk("sim_end", {4'h0, ia.gnt}, 8'h00);

        // Rotation with all four requesting and MAX_HOLD=2
        ib.req = 4'b1111;
        for (int i = 0; i < 14; i++) begin
            step();
            chk("rot_gnt", {4'h0, ib.gnt}, {4'h0, rot_exp[i]});
            chk("rot_busy", {7'h0, ib.busy}, {7'h0, |rot_exp[i]});
            if (rot_exp[i] != 4'h0)
                chk("rot_sel", {6'h0, ib.s1, ib.s0},
                    {6'h0, rot_exp[i][3] | rot_exp[i][2], rot_exp[i][3] | rot_exp[i][1]});
        end
        ib.req = 4'b0000;
        step(2);
        chk("rot_end", {4'h0, ib.gnt}, 8'h00);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
